// File: rtl/phys_reg_free_list_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | phys_reg_free_list_pkg : shared types and sizing for the free list        |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
package phys_reg_free_list_pkg;

  localparam int NUM_PHYS_REGS_DEFAULT = 64;
  localparam int NUM_ARCH_REGS_DEFAULT = 32;
  localparam int FREE_LIST_DEPTH       = NUM_PHYS_REGS_DEFAULT - NUM_ARCH_REGS_DEFAULT;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } free_list_state_t;

  // Pointer width that stays legal for a single-entry list.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/phys_reg_free_list_lutram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | phys_reg_free_list_lutram : 1 write / N async read storage, not reset     |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module phys_reg_free_list_lutram #(
  parameter int DATA_WIDTH     = 6,
  parameter int DEPTH          = 32,
  parameter int NUM_READ_PORTS = 1,
  parameter int ADDR_W         = 5
) (
  input  logic                                      clk,
  input  logic                                      we_i,
  input  logic [ADDR_W-1:0]                         waddr_i,
  input  logic [DATA_WIDTH-1:0]                     wdata_i,
  input  logic [NUM_READ_PORTS-1:0][ADDR_W-1:0]     raddr_i,
  output logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  generate
    for (genvar g = 0; g < NUM_READ_PORTS; g++) begin : g_read
      assign rdata_o[g] = mem_q[raddr_i[g]];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/phys_reg_free_list.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | phys_reg_free_list : FIFO of free physical registers with init sequencer |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
#(
  parameter int NUM_PHYS_REGS = NUM_PHYS_REGS_DEFAULT,
  parameter int NUM_ARCH_REGS = NUM_ARCH_REGS_DEFAULT,
  parameter int USE_ZERO      = 0
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                init_start_i,
  output logic                                                ready_o,
  output logic                                                alloc_valid_o,
  output logic [$clog2(NUM_PHYS_REGS)-1:0]                    alloc_phys_addr_o,
  input  logic                                                alloc_pop_i,
  input  logic                                                release_valid_i,
  input  logic [$clog2(NUM_PHYS_REGS)-1:0]                    release_phys_addr_i,
  output logic [$clog2(NUM_PHYS_REGS-NUM_ARCH_REGS+1)-1:0]    free_count_o,
  output logic                                                overflow_error_o
);

  localparam int DEPTH  = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int ADDR_W = $clog2(NUM_PHYS_REGS);
  localparam int PTR_W  = clog2_min1(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0]  C_PTR_LAST   = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  C_CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] C_FIRST_FREE = ADDR_W'(NUM_ARCH_REGS);
  localparam logic [ADDR_W-1:0] C_LAST_FREE  = ADDR_W'(NUM_PHYS_REGS - 1);

  free_list_state_t  state_q, state_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              ready_q, ready_d;
  logic              ovf_q, ovf_d;

  logic              in_ready;
  logic              not_empty;
  logic              is_full;
  logic              rel_ok;
  logic              pop_acc;
  logic              rel_acc;
  logic              rel_drop;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wdata;
  logic [0:0][PTR_W-1:0]  mem_raddr;
  logic [0:0][ADDR_W-1:0] mem_rdata;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == C_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (state_q == READY);
  assign not_empty = (count_q != '0);
  assign is_full   = (count_q == C_CNT_FULL);
  assign rel_ok    = release_valid_i && ((USE_ZERO != 0) || (release_phys_addr_i != '0));

  assign pop_acc  = in_ready && !init_start_i && alloc_pop_i && not_empty;
  // A full list can still take a release when a pop frees the head slot this cycle.
  assign rel_acc  = in_ready && !init_start_i && rel_ok && (!is_full || pop_acc);
  assign rel_drop = in_ready && !init_start_i && rel_ok && is_full && !pop_acc;

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    init_cnt_d = init_cnt_q;
    ready_d    = ready_q;
    ovf_d      = ovf_q;
    if (init_start_i) begin
      state_d    = INIT;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      init_cnt_d = C_FIRST_FREE;
      ready_d    = 1'b0;
      ovf_d      = 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          tail_d     = ptr_inc(tail_q);
          count_d    = count_q + 1'b1;
          init_cnt_d = init_cnt_q + 1'b1;
          if (init_cnt_q == C_LAST_FREE) begin
            state_d = READY;
            ready_d = 1'b1;
          end
        end
        READY: begin
          if (pop_acc) head_d = ptr_inc(head_q);
          if (rel_acc) tail_d = ptr_inc(tail_q);
          if (pop_acc && !rel_acc) begin
            count_d = count_q - 1'b1;
          end else if (rel_acc && !pop_acc) begin
            count_d = count_q + 1'b1;
          end
          if (rel_drop) ovf_d = 1'b1;
        end
        default: state_d = INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      init_cnt_q <= C_FIRST_FREE;
      ready_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      init_cnt_q <= init_cnt_d;
      ready_q    <= ready_d;
      ovf_q      <= ovf_d;
    end
  end

  assign mem_we       = (!in_ready && !init_start_i) || rel_acc;
  assign mem_wdata    = in_ready ? release_phys_addr_i : init_cnt_q;
  assign mem_raddr[0] = head_q;

  phys_reg_free_list_lutram #(
    .DATA_WIDTH     (ADDR_W),
    .DEPTH          (DEPTH),
    .NUM_READ_PORTS (1),
    .ADDR_W         (PTR_W)
  ) u_storage (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (tail_q),
    .wdata_i (mem_wdata),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  assign ready_o           = ready_q;
  assign alloc_valid_o     = ready_q && not_empty;
  assign alloc_phys_addr_o = mem_rdata[0];
  assign free_count_o      = count_q;
  assign overflow_error_o  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_phys_reg_free_list.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_phys_reg_free_list : directed self-checking bench for the free list    |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_phys_reg_free_list;

  logic       clk = 1'b0;
  logic       rst;
  int         total = 0;
  int         bad   = 0;

  logic       a_init, a_pop, a_rel, a_ready, a_valid, a_ovf;
  logic [5:0] a_raddr, a_addr, a_cnt;
  logic       b_init, b_pop, b_rel, b_ready, b_valid, b_ovf;
  logic [5:0] b_raddr, b_addr, b_cnt;

  int unsigned q[$];

  always #5 clk = ~clk;

  phys_reg_free_list #(.NUM_PHYS_REGS(64), .NUM_ARCH_REGS(32), .USE_ZERO(0)) u_dut_a (
    .clk                 (clk),
    .rst                 (rst),
    .init_start_i        (a_init),
    .ready_o             (a_ready),
    .alloc_valid_o       (a_valid),
    .alloc_phys_addr_o   (a_addr),
    .alloc_pop_i         (a_pop),
    .release_valid_i     (a_rel),
    .release_phys_addr_i (a_raddr),
    .free_count_o        (a_cnt),
    .overflow_error_o    (a_ovf)
  );

  phys_reg_free_list #(.NUM_PHYS_REGS(64), .NUM_ARCH_REGS(32), .USE_ZERO(1)) u_dut_b (
    .clk                 (clk),
    .rst                 (rst),
    .init_start_i        (b_init),
    .ready_o             (b_ready),
    .alloc_valid_o       (b_valid),
    .alloc_phys_addr_o   (b_addr),
    .alloc_pop_i         (b_pop),
    .release_valid_i     (b_rel),
    .release_phys_addr_i (b_raddr),
    .free_count_o        (b_cnt),
    .overflow_error_o    (b_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_init = 0; a_pop = 0; a_rel = 0; a_raddr = '0;
    b_init = 0; b_pop = 0; b_rel = 0; b_raddr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", a_ready, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_count", a_cnt, 0);
    chk("rst_ovf", a_ovf, 0);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      chk("init_ready_low", a_ready, 0);
      chk("init_count", a_cnt, i);
      step();
    end
    chk("ready_at_32", a_ready, 1);
    chk("b_ready_at_32", b_ready, 1);
    chk("full_count", a_cnt, 32);
    chk("first_addr", a_addr, 32);

    // Drain: initial contents come out in order 32..63.
    for (int i = 0; i < 32; i++) begin
      chk("drain_valid", a_valid, 1);
      chk("drain_addr", a_addr, 32 + i);
      a_pop = 1;
      step();
    end
    a_pop = 0;
    chk("empty_valid", a_valid, 0);
    chk("empty_count", a_cnt, 0);

    // Pop on an empty list is refused while the release lands.
    a_pop = 1; a_rel = 1; a_raddr = 6'd5;
    step();
    a_pop = 0; a_rel = 0;
    chk("empty_rel_count", a_cnt, 1);
    chk("empty_rel_valid", a_valid, 1);
    chk("empty_rel_addr", a_addr, 5);
    q.push_back(5);

    a_rel = 1; a_raddr = 6'd0;
    step();
    a_rel = 0;
    chk("zero_drop_count", a_cnt, 1);
    chk("zero_drop_ovf", a_ovf, 0);

    for (int i = 0; i < 9; i++) begin
      a_rel = 1; a_raddr = 6'(10 + i); q.push_back(10 + i);
      step();
    end
    a_rel = 0;
    chk("count_10", a_cnt, 10);

    // Steady state pop+release across pointer wrap.
    a_pop = 1; a_rel = 1; a_raddr = 6'd40;
    for (int i = 0; i < 50; i++) begin
      chk("steady_addr", a_addr, q[0]);
      chk("steady_count", a_cnt, 10);
      void'(q.pop_front());
      q.push_back(40);
      step();
    end
    a_pop = 0; a_rel = 0;
    chk("steady_end_count", a_cnt, 10);

    for (int i = 0; i < 22; i++) begin
      a_rel = 1; a_raddr = 6'(20 + i); q.push_back(20 + i);
      step();
    end
    a_rel = 0;
    chk("refull_count", a_cnt, 32);
    chk("refull_ovf", a_ovf, 0);

    a_pop = 1; a_rel = 1; a_raddr = 6'd7;
    chk("full_swap_addr", a_addr, q[0]);
    void'(q.pop_front());
    q.push_back(7);
    step();
    a_pop = 0; a_rel = 0;
    chk("full_swap_count", a_cnt, 32);
    chk("full_swap_ovf", a_ovf, 0);

    a_rel = 1; a_raddr = 6'd7;
    step();
    a_rel = 0;
    chk("overflow_count", a_cnt, 32);
    chk("overflow_flag", a_ovf, 1);

    for (int i = 0; i < 20; i++) begin
      chk("post_ovf_addr", a_addr, q[0]);
      void'(q.pop_front());
      a_pop = 1;
      step();
    end
    a_pop = 0;
    chk("count_12", a_cnt, 12);
    chk("ovf_sticky", a_ovf, 1);

    // USE_ZERO=1 instance accepts address 0.
    b_pop = 1;
    step();
    b_pop = 0;
    chk("b_count_31", b_cnt, 31);
    b_rel = 1; b_raddr = 6'd0;
    step();
    b_rel = 0;
    chk("b_zero_count", b_cnt, 32);
    for (int i = 0; i < 31; i++) begin
      chk("b_addr", b_addr, 33 + i);
      b_pop = 1;
      step();
    end
    b_pop = 0;
    chk("b_zero_out_valid", b_valid, 1);
    chk("b_zero_out_addr", b_addr, 0);

    // init_start discards the concurrent pop/release and clears state.
    a_init = 1; a_pop = 1; a_rel = 1; a_raddr = 6'd9;
    step();
    a_init = 0; a_pop = 0; a_rel = 0;
    chk("reinit_ready", a_ready, 0);
    chk("reinit_ovf", a_ovf, 0);
    chk("reinit_count", a_cnt, 0);
    chk("reinit_valid", a_valid, 0);
    for (int i = 0; i < 10; i++) begin
      chk("reinit_fill", a_cnt, i);
      step();
    end

    rst = 1'b1;
    #1;
    chk("midinit_rst_count", a_cnt, 0);
    chk("midinit_rst_ready", a_ready, 0);
    #2;
    rst = 1'b0;
    step();
    for (int i = 1; i < 32; i++) begin
      chk("refill_ready_low", a_ready, 0);
      chk("refill_count", a_cnt, i);
      step();
    end
    chk("refill_ready", a_ready, 1);
    chk("refill_count_full", a_cnt, 32);
    chk("refill_first_addr", a_addr, 32);
    chk("refill_valid", a_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
- Allocation controller for the 64-entry physical register file and its in-use tracking.
- Holds a FIFO of free physical register addresses and hands one to decode per cycle as the new rd mapping.
- Takes freed addresses back from retire, one per cycle.
- After reset or init_start, a sequencer fills the list with physical registers NUM_ARCH_REGS..NUM_PHYS_REGS-1 before allocation is allowed.

Parameters:
- NUM_PHYS_REGS, 64, physical register count; must equal the register file depth.
- NUM_ARCH_REGS, 32, architectural registers; physical 0..NUM_ARCH_REGS-1 start out mapped, so they are never loaded into the list at init.
- USE_ZERO, 0, if 0, physical address 0 is never accepted on release.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- init_start  in  1  restart the init sequence (driven from gc.init_clear)
- ready  out  1  init complete, list operational
- alloc_valid  out  1  ready and list non-empty
- alloc_phys_addr  out  $clog2(NUM_PHYS_REGS)  head entry; valid only while alloc_valid
- alloc_pop  in  1  consume head (decode_advance & uses_rd & rd!=0); ignored unless alloc_valid
- release_valid  in  1  return an address to the list
- release_phys_addr  in  $clog2(NUM_PHYS_REGS)  address being freed
- free_count  out  $clog2(NUM_PHYS_REGS-NUM_ARCH_REGS+1)  current number of entries
- overflow_error  out  1  sticky: a release was dropped because the list was full

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - state=INIT, init counter=NUM_ARCH_REGS, head=tail=0.
  - free_count=0, ready=0, alloc_valid=0, overflow_error=0.
- Storage: DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS entries.
  - Storage is not reset.
  - head/tail pointers are $clog2(DEPTH) bits, wrap modulo DEPTH, with no extra wrap bit; full/empty come from free_count.
- INIT state:
  - Each cycle writes the counter value at tail, increments tail, counter and free_count.
  - After writing NUM_PHYS_REGS-1 (DEPTH cycles) the block moves to READY.
  - ready rises in the cycle after the last write: cycle DEPTH after reset deassertion, counting from 0.
  - alloc_pop and release_valid are ignored during INIT.
- READY state:
  - alloc_phys_addr = storage[head], combinational read.
  - Accepted pop: head+1, free_count-1, effective at the next edge.
  - Accepted release: storage[tail]=addr, tail+1, free_count+1.
  - Simultaneous pop and release: both pointers advance and free_count is unchanged.
    - At free_count=0 the pop is not accepted (alloc_valid=0) and the release is accepted.
    - At free_count=DEPTH a simultaneous pop+release is accepted, since the slot is freed that same cycle.
  - A release with free_count=DEPTH and no accepted pop is dropped and sets overflow_error; it is cleared only by rst or init_start.
  - A release of address 0 when USE_ZERO=0 is silently dropped.
- init_start (any state, synchronous):
  - Next cycle: state=INIT, head=tail=0, free_count=0, counter=NUM_ARCH_REGS, ready=0, overflow_error=0.
  - Pops and releases in the init_start cycle are discarded.
- rst mid-INIT or mid-operation: immediate return to reset values; the full init sequence reruns.
- free_count never exceeds DEPTH and never underflows.

Decomposition:
- cva5_types: reuse phys_addr_t.
- cva5_config: add FREE_LIST_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS, and a free_list_state_t enum {INIT, READY}.
- Storage sub-module: existing lutram_1w_mr with NUM_READ_PORTS=1, DEPTH=FREE_LIST_DEPTH, DATA_TYPE=phys_addr_t.
  - Write address = tail; read address = head.
  - Write data = init counter in INIT, release_phys_addr in READY.

Test Plan:
- Reset release -> ready=0 for cycles 0..31, ready=1 at cycle 32; free_count=32, alloc_phys_addr=32; 32 consecutive pops return 32,33,...,63, then alloc_valid=0, free_count=0.
- Empty list, release_valid with addr 5 plus alloc_pop in the same cycle -> pop ignored, free_count=1; next cycle alloc_valid=1, alloc_phys_addr=5.
- free_count=10, pop and release (addr 40) every cycle for 50 cycles -> free_count stays 10; pointers wrap past 31 correctly; addresses come out in FIFO order.
- Full list (32), release addr 7 without pop -> free_count stays 32, overflow_error=1; same release with a pop -> accepted, no error.
- release addr 0 with USE_ZERO=0 -> free_count unchanged, no error; with USE_ZERO=1 -> accepted, count+1.
- init_start asserted in READY with free_count=12 and overflow_error=1 (and rst pulsed at cycle 10 of INIT) -> next cycle ready=0, overflow_error=0, free_count=0; full 32-cycle refill; first alloc_phys_addr=32.
